core: RTL and testbench



---
 rtl/core.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core.sv
// Instruction memory: 4096x32 words, combinational read; images arrive through memory initialisation.
// Latency: read is combinational; the loader port writes on the rising edge.
// Backpressure: none; a read is always served in the same cycle.
module core_imem (
    input  logic        clk,
    input  logic        load_en,
    input  logic [11:0] load_addr,
    input  logic [31:0] load_data,
    input  logic [11:0] addr,
    output logic [31:0] data_out
);
    logic [31:0] mem_array [0:4095];

    // Optional in-system loader; the core ties it off and relies on initial contents.
    always_ff @(posedge clk) begin
        if (load_en) mem_array[load_addr] <= load_data;
    end

    assign data_out = mem_array[addr];
endmodule

// Data memory: 4096x32 words, combinational word read, byte-masked write.
// Latency: read is combinational; the write lands on the rising edge.
// Backpressure: none; every access completes in the issuing cycle.
module core_dmem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic [3:0]  be,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:4095];

    // Byte-lane write; contents survive reset, but nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wen) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// Register file: 32x32, two combinational read ports, one write port, x0 hardwired to zero.
// Latency: reads combinational; a write is visible the cycle after it is issued.
// Backpressure: none.
module core_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    input  logic        wen,
    input  logic [4:0]  wsel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] x10
);
    logic [31:0] registers [0:31];

    // Write port; all registers clear asynchronously on reset, x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) registers[r] <= 32'd0;
        end else if (wen && (wsel != 5'd0)) begin
            registers[wsel] <= wdata;
        end
    end

    assign rdata1 = (rsel1 == 5'd0) ? 32'd0 : registers[rsel1];
    assign rdata2 = (rsel2 == 5'd0) ? 32'd0 : registers[rsel2];
    assign x10    = registers[10];
endmodule

// Control unit: decodes opcode/funct3/funct7[5] into datapath selects and write enables.
// Latency: purely combinational.
// Backpressure: none; unsupported opcodes decode to a NOP (no writes, PC+4).
module core_ctrl (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       RF_wen,
    output logic       DM_wen,
    output logic [1:0] ALU_OP1_SEL,
    output logic       ALU_OP2_SEL,
    output logic [1:0] RF_wdata_sel,
    output logic [3:0] alu_op,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 -> ALU op; SUB only exists for OP, SRA uses funct7[5] for both OP and OP-IMM.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input logic is_reg);
        case (f3)
            3'b000:  arith_op = (is_reg && f7) ? 4'd1 : 4'd0;
            3'b001:  arith_op = 4'd2;
            3'b010:  arith_op = 4'd3;
            3'b011:  arith_op = 4'd4;
            3'b100:  arith_op = 4'd5;
            3'b101:  arith_op = f7 ? 4'd7 : 4'd6;
            3'b110:  arith_op = 4'd8;
            default: arith_op = 4'd9;
        endcase
    endfunction

    // Opcode decode; defaults describe a NOP so anything unrecognised has no side effect.
    always_comb begin
        RF_wen       = 1'b0;
        DM_wen       = 1'b0;
        ALU_OP1_SEL  = 2'd0;
        ALU_OP2_SEL  = 1'b1;
        RF_wdata_sel = 2'd0;
        alu_op       = 4'd0;
        is_branch    = 1'b0;
        is_jal       = 1'b0;
        is_jalr      = 1'b0;
        case (opcode)
            OPC_LUI:    begin RF_wen = 1'b1; ALU_OP1_SEL = 2'd2; end
            OPC_AUIPC:  begin RF_wen = 1'b1; ALU_OP1_SEL = 2'd1; end
            OPC_JAL:    begin RF_wen = 1'b1; RF_wdata_sel = 2'd2; is_jal = 1'b1; end
            OPC_JALR:   begin RF_wen = 1'b1; RF_wdata_sel = 2'd2; is_jalr = 1'b1; end
            OPC_BRANCH: begin ALU_OP2_SEL = 1'b0; is_branch = 1'b1; end
            OPC_LOAD:   begin RF_wen = 1'b1; RF_wdata_sel = 2'd1; end
            OPC_STORE:  begin DM_wen = 1'b1; end
            OPC_OPIMM:  begin RF_wen = 1'b1; alu_op = arith_op(funct3, funct7_5, 1'b0); end
            OPC_OP:     begin
                RF_wen      = 1'b1;
                ALU_OP2_SEL = 1'b0;
                alu_op      = arith_op(funct3, funct7_5, 1'b1);
            end
            default: ;
        endcase
    end
endmodule

// Single-cycle RV32I core with private instruction/data memories; LEDs mirror ~x10[5:0].
// Latency: one instruction per clock; PC, register and memory writes commit together.
// Backpressure: none; the core never stalls.
module core (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] leds
);
    logic [31:0] program_counter, instruction, pc_next, pc_plus4;
    logic        branch_taken;
    logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
    logic [31:0] RF_rdata1, RF_rdata2, RF_wdata, rf_x10;
    logic [1:0]  RF_wdata_sel;
    logic        RF_wen;
    logic [1:0]  ALU_OP1_SEL;
    logic        ALU_OP2_SEL;
    logic [31:0] ALU_A, ALU_B, ALU_OUT;
    logic [3:0]  alu_op;
    logic [31:0] Immediate_imm, DM_OUT, load_data, store_data;
    logic [3:0]  store_be;
    logic        DM_wen, is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign funct3   = instruction[14:12];
    assign RF_rsel1 = instruction[19:15];
    assign RF_rsel2 = instruction[24:20];
    assign RF_wsel  = instruction[11:7];
    assign pc_plus4 = program_counter + 32'd4;

    core_imem im (
        .clk(clk), .load_en(1'b0), .load_addr(12'd0), .load_data(32'd0),
        .addr(program_counter[13:2]), .data_out(instruction)
    );

    core_ctrl cu (
        .opcode(instruction[6:0]), .funct3(funct3), .funct7_5(instruction[30]),
        .RF_wen(RF_wen), .DM_wen(DM_wen), .ALU_OP1_SEL(ALU_OP1_SEL), .ALU_OP2_SEL(ALU_OP2_SEL),
        .RF_wdata_sel(RF_wdata_sel), .alu_op(alu_op),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr)
    );

    core_regfile rf (
        .clk(clk), .rst_n(rst_n), .rsel1(RF_rsel1), .rsel2(RF_rsel2),
        .wen(RF_wen), .wsel(RF_wsel), .wdata(RF_wdata),
        .rdata1(RF_rdata1), .rdata2(RF_rdata2), .x10(rf_x10)
    );

    core_dmem dm (
        .clk(clk), .rst_n(rst_n), .wen(DM_wen), .be(store_be),
        .addr(ALU_OUT[13:2]), .wdata(store_data), .rdata(DM_OUT)
    );

    // Immediate format chosen by opcode; I-type is the fallback for loads, JALR and OP-IMM.
    always_comb begin
        Immediate_imm = {{20{instruction[31]}}, instruction[31:20]};
        case (instruction[6:0])
            7'b0100011: Immediate_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            7'b1100011: Immediate_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                                         instruction[30:25], instruction[11:8], 1'b0};
            7'b0110111,
            7'b0010111: Immediate_imm = {instruction[31:12], 12'd0};
            7'b1101111: Immediate_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                         instruction[20], instruction[30:21], 1'b0};
            default: ;
        endcase
    end

    // Operand muxes and ALU.
    always_comb begin
        case (ALU_OP1_SEL)
            2'd1:    ALU_A = program_counter;
            2'd2:    ALU_A = 32'd0;
            default: ALU_A = RF_rdata1;
        endcase
        ALU_B = ALU_OP2_SEL ? Immediate_imm : RF_rdata2;
        case (alu_op)
            4'd1:    ALU_OUT = ALU_A - ALU_B;
            4'd2:    ALU_OUT = ALU_A << ALU_B[4:0];
            4'd3:    ALU_OUT = {31'd0, $signed(ALU_A) < $signed(ALU_B)};
            4'd4:    ALU_OUT = {31'd0, ALU_A < ALU_B};
            4'd5:    ALU_OUT = ALU_A ^ ALU_B;
            4'd6:    ALU_OUT = ALU_A >> ALU_B[4:0];
            4'd7:    ALU_OUT = $unsigned($signed(ALU_A) >>> ALU_B[4:0]);
            4'd8:    ALU_OUT = ALU_A | ALU_B;
            4'd9:    ALU_OUT = ALU_A & ALU_B;
            default: ALU_OUT = ALU_A + ALU_B;
        endcase
    end

    // Branch comparator and next-PC selection; JALR target is the ALU sum with bit 0 cleared.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (RF_rdata1 == RF_rdata2);
            3'b001:  branch_taken = (RF_rdata1 != RF_rdata2);
            3'b100:  branch_taken = ($signed(RF_rdata1) <  $signed(RF_rdata2));
            3'b101:  branch_taken = ($signed(RF_rdata1) >= $signed(RF_rdata2));
            3'b110:  branch_taken = (RF_rdata1 <  RF_rdata2);
            3'b111:  branch_taken = (RF_rdata1 >= RF_rdata2);
            default: branch_taken = 1'b0;
        endcase
        branch_taken = branch_taken & is_branch;
        if (is_jalr)                     pc_next = ALU_OUT & 32'hFFFF_FFFE;
        else if (is_jal || branch_taken) pc_next = program_counter + Immediate_imm;
        else                             pc_next = pc_plus4;
    end

    // Load lane extraction/extension and store lane replication with byte enables.
    always_comb begin
        load_byte = DM_OUT[8*ALU_OUT[1:0] +: 8];
        load_half = ALU_OUT[1] ? DM_OUT[31:16] : DM_OUT[15:0];
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = DM_OUT;
        endcase
        case (funct3)
            3'b000: begin
                store_data = {4{RF_rdata2[7:0]}};
                store_be   = 4'b0001 << ALU_OUT[1:0];
            end
            3'b001: begin
                store_data = {2{RF_rdata2[15:0]}};
                store_be   = ALU_OUT[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = RF_rdata2;
                store_be   = 4'b1111;
            end
        endcase
    end

    // Write-back source select.
    always_comb begin
        case (RF_wdata_sel)
            2'd1:    RF_wdata = load_data;
            2'd2:    RF_wdata = pc_plus4;
            default: RF_wdata = ALU_OUT;
        endcase
    end

    // Program counter; reset returns to address 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) program_counter <= 32'd0;
        else        program_counter <= pc_next;
    end

    assign leds = ~rf_x10[5:0];
endmodule

// File: tb/tb_core.sv
module tb_core;
    logic       clk;
    logic       rst_n;
    logic [5:0] leds;
    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    core dut (.clk(clk), .rst_n(rst_n), .leds(leds));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    // Hold reset and fill the start of instruction memory with NOPs.
    task automatic prog_begin();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 128; k++) dut.im.mem_array[k] = NOP;
    endtask

    // Release reset away from the active edge.
    task automatic prog_start();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Execute n instructions, then settle on the falling edge.
    task automatic run(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        prog_begin();
        dut.im.mem_array[0] = addi(5'd1, 5'd0, 32'd5);
        @(posedge clk);
        @(negedge clk);
        checks++; if (dut.program_counter !== 32'd0) begin failures++;
            $display("FAIL reset_pc got=%h exp=%h", dut.program_counter, 32'd0); end
        checks++; if (leds !== 6'b111111) begin failures++;
            $display("FAIL reset_leds got=%b exp=%b", leds, 6'b111111); end
        checks++; if (dut.rf.registers[1] !== 32'd0) begin failures++;
            $display("FAIL reset_no_write got=%h exp=%h", dut.rf.registers[1], 32'd0); end
        prog_start();
        checks++; if (dut.instruction !== 32'h0050_0093) begin failures++;
            $display("FAIL reset_first_fetch got=%h exp=%h", dut.instruction, 32'h0050_0093); end
        run(1);
        checks++; if (dut.rf.registers[1] !== 32'd5 || dut.program_counter !== 32'd4) begin failures++;
            $display("FAIL reset_first_exec x1=%h pc=%h exp x1=5 pc=4", dut.rf.registers[1], dut.program_counter); end
    endtask

    task automatic test_alu();
        prog_begin();
        dut.im.mem_array[0]  = addi(5'd1, 5'd0, 32'd5);
        dut.im.mem_array[1]  = addi(5'd2, 5'd0, -32'sd3);
        dut.im.mem_array[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        dut.im.mem_array[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
        dut.im.mem_array[4]  = enc_u(20'h12345, 5'd5, 7'b0110111);
        dut.im.mem_array[5]  = addi(5'd0, 5'd0, 32'd7);
        dut.im.mem_array[6]  = enc_i(32'h401, 5'd2, 3'b101, 5'd7, 7'b0010011);
        dut.im.mem_array[7]  = enc_i(32'd28, 5'd2, 3'b101, 5'd8, 7'b0010011);
        dut.im.mem_array[8]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd9);
        dut.im.mem_array[9]  = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd11);
        dut.im.mem_array[10] = enc_u(20'h00001, 5'd12, 7'b0010111);
        dut.im.mem_array[11] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd13);
        prog_start();
        run(12);
        checks++; if (dut.rf.registers[3] !== 32'd2) begin failures++;
            $display("FAIL alu_add got=%h exp=%h", dut.rf.registers[3], 32'd2); end
        checks++; if (dut.rf.registers[4] !== 32'd8) begin failures++;
            $display("FAIL alu_sub got=%h exp=%h", dut.rf.registers[4], 32'd8); end
        checks++; if (dut.rf.registers[5] !== 32'h1234_5000) begin failures++;
            $display("FAIL alu_lui got=%h exp=%h", dut.rf.registers[5], 32'h1234_5000); end
        checks++; if (dut.rf.registers[0] !== 32'd0) begin failures++;
            $display("FAIL alu_x0 got=%h exp=%h", dut.rf.registers[0], 32'd0); end
        checks++; if (dut.rf.registers[7] !== 32'hFFFF_FFFE) begin failures++;
            $display("FAIL alu_srai got=%h exp=%h", dut.rf.registers[7], 32'hFFFF_FFFE); end
        checks++; if (dut.rf.registers[8] !== 32'h0000_000F) begin failures++;
            $display("FAIL alu_srli got=%h exp=%h", dut.rf.registers[8], 32'h0000_000F); end
        checks++; if (dut.rf.registers[9] !== 32'd1 || dut.rf.registers[11] !== 32'd0) begin failures++;
            $display("FAIL alu_slt_sltu got=%h/%h exp=1/0", dut.rf.registers[9], dut.rf.registers[11]); end
        checks++; if (dut.rf.registers[12] !== 32'h0000_1028) begin failures++;
            $display("FAIL alu_auipc got=%h exp=%h", dut.rf.registers[12], 32'h0000_1028); end
        checks++; if (dut.rf.registers[13] !== 32'd5 || dut.program_counter !== 32'd48) begin failures++;
            $display("FAIL alu_and_pc got=%h pc=%h exp=5 pc=30", dut.rf.registers[13], dut.program_counter); end
    endtask

    task automatic test_branches();
        prog_begin();
        dut.im.mem_array[0] = addi(5'd1, 5'd0, 32'd1);
        dut.im.mem_array[1] = addi(5'd2, 5'd0, -32'sd1);
        dut.im.mem_array[2] = enc_b(32'd8, 5'd2, 5'd1, 3'b110);
        dut.im.mem_array[3] = addi(5'd3, 5'd0, 32'd1);
        dut.im.mem_array[4] = enc_b(32'd8, 5'd2, 5'd1, 3'b100);
        dut.im.mem_array[5] = addi(5'd4, 5'd0, 32'd2);
        dut.im.mem_array[6] = enc_b(32'd8, 5'd1, 5'd1, 3'b001);
        dut.im.mem_array[7] = enc_b(32'd8, 5'd2, 5'd1, 3'b101);
        dut.im.mem_array[8] = addi(5'd3, 5'd0, 32'd7);
        prog_start();
        run(2);
        checks++; if (dut.branch_taken !== 1'b1) begin failures++;
            $display("FAIL br_bltu_taken got=%b exp=1", dut.branch_taken); end
        run(1);
        checks++; if (dut.program_counter !== 32'd16 || dut.branch_taken !== 1'b0) begin failures++;
            $display("FAIL br_blt_not_taken pc=%h taken=%b exp pc=10 taken=0", dut.program_counter, dut.branch_taken); end
        run(3);
        checks++; if (dut.program_counter !== 32'd28 || dut.branch_taken !== 1'b1) begin failures++;
            $display("FAIL br_bne_bge pc=%h taken=%b exp pc=1c taken=1", dut.program_counter, dut.branch_taken); end
        run(1);
        checks++; if (dut.program_counter !== 32'd36 || dut.rf.registers[3] !== 32'd0
                      || dut.rf.registers[4] !== 32'd2) begin failures++;
            $display("FAIL br_path pc=%h x3=%h x4=%h exp pc=24 x3=0 x4=2",
                     dut.program_counter, dut.rf.registers[3], dut.rf.registers[4]); end
    endtask

    task automatic test_jumps();
        prog_begin();
        dut.im.mem_array[4] = enc_j(32'd8, 5'd1);
        dut.im.mem_array[6] = addi(5'd5, 5'd0, 32'd65);
        dut.im.mem_array[7] = enc_i(32'd0, 5'd5, 3'b000, 5'd6, 7'b1100111);
        prog_start();
        run(5);
        checks++; if (dut.rf.registers[1] !== 32'h14 || dut.program_counter !== 32'h18) begin failures++;
            $display("FAIL jal x1=%h pc=%h exp x1=14 pc=18", dut.rf.registers[1], dut.program_counter); end
        run(2);
        checks++; if (dut.program_counter !== 32'h40 || dut.rf.registers[6] !== 32'h20) begin failures++;
            $display("FAIL jalr_odd pc=%h x6=%h exp pc=40 x6=20", dut.program_counter, dut.rf.registers[6]); end
    endtask

    task automatic test_loadstore();
        prog_begin();
        dut.im.mem_array[0]  = enc_u(20'h80FF8, 5'd6, 7'b0110111);
        dut.im.mem_array[1]  = addi(5'd6, 5'd6, -32'sd255);
        dut.im.mem_array[2]  = enc_s(32'd0, 5'd6, 5'd0, 3'b010);
        dut.im.mem_array[3]  = enc_i(32'd3, 5'd0, 3'b000, 5'd1, 7'b0000011);
        dut.im.mem_array[4]  = enc_i(32'd3, 5'd0, 3'b100, 5'd2, 7'b0000011);
        dut.im.mem_array[5]  = enc_i(32'd2, 5'd0, 3'b001, 5'd3, 7'b0000011);
        dut.im.mem_array[6]  = addi(5'd4, 5'd0, 32'hAA);
        dut.im.mem_array[7]  = enc_s(32'd1, 5'd4, 5'd0, 3'b000);
        dut.im.mem_array[8]  = enc_i(32'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
        dut.im.mem_array[9]  = enc_i(32'd0, 5'd0, 3'b101, 5'd7, 7'b0000011);
        dut.im.mem_array[10] = enc_s(32'd6, 5'd4, 5'd0, 3'b001);
        dut.im.mem_array[11] = enc_i(32'd4, 5'd0, 3'b010, 5'd8, 7'b0000011);
        prog_start();
        run(4);
        checks++; if (dut.dm.mem[0] !== 32'h80FF_7F01) begin failures++;
            $display("FAIL ls_sw got=%h exp=%h", dut.dm.mem[0], 32'h80FF_7F01); end
        checks++; if (dut.rf.registers[1] !== 32'hFFFF_FF80) begin failures++;
            $display("FAIL ls_lb got=%h exp=%h", dut.rf.registers[1], 32'hFFFF_FF80); end
        run(2);
        checks++; if (dut.rf.registers[2] !== 32'h0000_0080) begin failures++;
            $display("FAIL ls_lbu got=%h exp=%h", dut.rf.registers[2], 32'h0000_0080); end
        checks++; if (dut.rf.registers[3] !== 32'hFFFF_80FF) begin failures++;
            $display("FAIL ls_lh got=%h exp=%h", dut.rf.registers[3], 32'hFFFF_80FF); end
        run(3);
        checks++; if (dut.rf.registers[5] !== 32'h80FF_AA01) begin failures++;
            $display("FAIL ls_sb_lw got=%h exp=%h", dut.rf.registers[5], 32'h80FF_AA01); end
        run(3);
        checks++; if (dut.rf.registers[7] !== 32'h0000_AA01) begin failures++;
            $display("FAIL ls_lhu got=%h exp=%h", dut.rf.registers[7], 32'h0000_AA01); end
        checks++; if (dut.rf.registers[8][31:16] !== 16'h00AA) begin failures++;
            $display("FAIL ls_sh_upper got=%h exp=%h", dut.rf.registers[8][31:16], 16'h00AA); end
    endtask

    task automatic test_unsupported();
        prog_begin();
        dut.im.mem_array[0] = addi(5'd1, 5'd0, 32'd9);
        dut.im.mem_array[1] = {12'h300, 5'd1, 3'b001, 5'd5, 7'b1110011};
        dut.im.mem_array[2] = 32'h0FF0_000F;
        dut.im.mem_array[3] = 32'hFFFF_FFFF;
        prog_start();
        run(4);
        checks++; if (dut.rf.registers[5] !== 32'd0 || dut.rf.registers[31] !== 32'd0
                      || dut.program_counter !== 32'd16) begin failures++;
            $display("FAIL unsupported_nop x5=%h x31=%h pc=%h exp 0/0/10",
                     dut.rf.registers[5], dut.rf.registers[31], dut.program_counter); end
    endtask

    task automatic test_leds_and_midreset();
        prog_begin();
        dut.im.mem_array[0] = addi(5'd10, 5'd0, 32'h2A);
        dut.im.mem_array[1] = addi(5'd1, 5'd0, 32'd5);
        prog_start();
        checks++; if (leds !== 6'b111111) begin failures++;
            $display("FAIL leds_before got=%b exp=%b", leds, 6'b111111); end
        run(1);
        checks++; if (leds !== 6'b010101) begin failures++;
            $display("FAIL leds_x10 got=%b exp=%b", leds, 6'b010101); end
        run(1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dut.program_counter !== 32'd0 || leds !== 6'b111111) begin failures++;
            $display("FAIL midreset_async pc=%h leds=%b exp pc=0 leds=111111", dut.program_counter, leds); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (dut.instruction !== 32'h02A0_0513) begin failures++;
            $display("FAIL midreset_refetch got=%h exp=%h", dut.instruction, 32'h02A0_0513); end
        run(1);
        checks++; if (leds !== 6'b010101 || dut.rf.registers[1] !== 32'd0) begin failures++;
            $display("FAIL midreset_restart leds=%b x1=%h exp leds=010101 x1=0", leds, dut.rf.registers[1]); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_alu();
        test_branches();
        test_jumps();
        test_loadstore();
        test_unsupported();
        test_leds_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
